quiz_arbiter: RTL and testbench
===============================

# quiz_arbiter

Round controller and arbiter for the four-contestant quiz buzzer. It sequences each round (idle → armed → answering → timeout), grants the single shared answer slot to the first contestant to press, and flags false starts. It runs the 30 s answer countdown from an internal 1 Hz prescaler and applies host add/subtract to the granted contestant's score. It sits between the debounced key/button inputs and the LED, buzzer and segment-display logic.

## Interface
- TICK_DIV, 12000000: clk cycles per 1 s tick (prescaler counter width 24).
- ANSWER_SEC, 30: answer window in seconds; remain width 5.
- INIT_SCORE, 5: score loaded on reset and on clr.
- MAX_SCORE, 9: score saturation ceiling; floor is 0.

- clk  in  1  system clock, 12 MHz
- rst  in  1  reset, asynchronous, active-low
- arm  in  1  host start-round pulse, single-cycle, debounced
- clr  in  1  host clear pulse, single-cycle
- add  in  1  host award pulse, single-cycle
- sub  in  1  host penalty pulse, single-cycle
- req  in  4  contestant key levels, active-high, debounced; req[0] = contestant 1
- grant  out  4  one-hot winner, registered
- foul  out  4  sticky false-start flags
- state  out  2  00 IDLE, 01 ARMED, 10 ANSWER, 11 TIMEOUT
- remain  out  5  seconds left in the answer window
- buzz  out  1  timeout alarm, high in TIMEOUT
- scores  out  16  nibble i = score of contestant i+1, binary 0..MAX_SCORE

## Operation
- Reset values:
  - state = IDLE; grant, foul, buzz = 0; remain = ANSWER_SEC.
  - Every scores nibble = INIT_SCORE.
  - Synchronizer and edge flops = 0. A key held through reset therefore reads as a rising edge once reset releases.
- req input path: 2-flop synchronizer, then edge register. rise = sync & ~prev.
- IDLE:
  - rise[i] sets foul[i].
  - arm moves to ARMED.
- ARMED:
  - Eligible presses are rise & ~foul.
  - If any press is eligible, grant the lowest index, load remain = ANSWER_SEC, clear the prescaler, and move to ANSWER.
  - Fouled contestants are locked out for this round.
  - arm while in ARMED clears foul; state does not change.
- ANSWER:
  - Every TICK_DIV cycles, remain decrements.
  - The tick that makes remain reach 0 moves the block to TIMEOUT.
  - Presses on req are ignored.
- TIMEOUT:
  - buzz = 1, grant is held, remain = 0.
  - arm clears grant and moves to ARMED with no score change.
- Scoring (ANSWER or TIMEOUT only):
  - add: granted nibble +1, saturating at MAX_SCORE.
  - sub: granted nibble −1, saturating at 0.
  - add and sub in the same cycle: no score change.
  - After any of these three cases: grant = 0, foul = 0, buzz = 0, remain = ANSWER_SEC, state = IDLE.
  - add/sub in IDLE or ARMED are ignored.
- clr, any state:
  - All nibbles = INIT_SCORE; state = IDLE; grant, foul, buzz = 0; remain = ANSWER_SEC.
  - clr has priority over every other input in the same cycle.
- Arithmetic is 4-bit per nibble and never wraps.

## Timing
- req → grant:
  - req rises before clk edge E0.
  - The synchronizer output is high after E1.
  - grant and state = ANSWER are visible after E2.
- Simultaneous eligible rises in the same cycle: lowest index wins; the other presses are discarded.
- remain decrements every TICK_DIV cycles, the first time exactly TICK_DIV cycles after grant asserts.
- TIMEOUT and buzz assert ANSWER_SEC × TICK_DIV cycles after grant asserts.
- Score update, grant clear and state change are all visible the cycle after the add/sub/clr pulse.
- arm → ARMED takes 1 cycle. A press whose rise coincides with the arm cycle is evaluated in IDLE and counts as a foul.
- Asynchronous reset mid-round:
  - All outputs return to their reset values immediately.
  - Scores are lost.

## Test plan
Run all scenarios with TICK_DIV=4 and ANSWER_SEC=3.
- Reset, arm, then req=0100 → grant=0100 on the 3rd edge, state=10, remain=3. add → scores nibble2 = 6, state=00, grant=0.
- Armed, req goes from 0000 to 0011 in one cycle → grant=0001. A later press of req[1] causes no change.
- req[3] rises in IDLE → foul=1000. arm, req=1000 → no grant. req=0010 → grant=0010. sub → nibble1 = 4, foul=0000.
- Grant, no host action → remain reads 3, 2, 1, 0 at 4-cycle spacing. After 12 cycles from grant, state=11 and buzz=1. add with score 9 → score stays 9, buzz=0, state=00.
- TIMEOUT, then add and sub together → scores unchanged, state=00. Mid-ANSWER clr → all nibbles = 5, state=00, grant=0.
- Assert rst low mid-ANSWER → grant=0, state=00, buzz=0 at once, without waiting for a clk edge.

Source files
------------

// File: rtl/quiz_arbiter.sv
// -----------------------------------------------------------------------------
// quiz_arbiter
// Round controller and answer-slot arbiter for a four-contestant quiz buzzer.
// Sequences IDLE -> ARMED -> ANSWER -> TIMEOUT, grants the answer slot to the
// first eligible contestant, flags false starts, runs the answer countdown
// from an internal prescaler and applies host add/subtract to the granted
// contestant's score.
//
// Ports
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   arm_i      host start-round pulse (one cycle)
//   clr_i      host clear pulse (one cycle), highest priority
//   add_i      host award pulse (one cycle)
//   sub_i      host penalty pulse (one cycle)
//   req_i      contestant key levels, req_i[0] = contestant 1
//   grant_o    one-hot winner
//   foul_o     sticky false-start flags
//   state_o    00 IDLE, 01 ARMED, 10 ANSWER, 11 TIMEOUT
//   remain_o   seconds left in the answer window
//   buzz_o     timeout alarm
//   scores_o   nibble i = score of contestant i+1
// -----------------------------------------------------------------------------
module quiz_arbiter #(
  parameter int unsigned TICK_DIV   = 12000000,
  parameter int unsigned ANSWER_SEC = 30,
  parameter int unsigned INIT_SCORE = 5,
  parameter int unsigned MAX_SCORE  = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        arm_i,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic        sub_i,
  input  logic [3:0]  req_i,
  output logic [3:0]  grant_o,
  output logic [3:0]  foul_o,
  output logic [1:0]  state_o,
  output logic [4:0]  remain_o,
  output logic        buzz_o,
  output logic [15:0] scores_o
);

  localparam logic [1:0]  ST_IDLE    = 2'b00;
  localparam logic [1:0]  ST_ARMED   = 2'b01;
  localparam logic [1:0]  ST_ANSWER  = 2'b10;
  localparam logic [1:0]  ST_TIMEOUT = 2'b11;

  localparam logic [23:0] TICK_LAST   = 24'(TICK_DIV - 1);
  localparam logic [4:0]  REMAIN_INIT = 5'(ANSWER_SEC);
  localparam logic [3:0]  SCORE_INIT  = 4'(INIT_SCORE);
  localparam logic [3:0]  SCORE_MAX   = 4'(MAX_SCORE);
  localparam logic [15:0] SCORES_INIT = {4{SCORE_INIT}};

  logic [3:0]  sync1_q, sync2_q, prev_q;
  logic [3:0]  rise_s, eligible_s;
  logic [1:0]  state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  foul_q, foul_d;
  logic [4:0]  remain_q, remain_d;
  logic        buzz_q, buzz_d;
  logic [15:0] scores_q, scores_d;
  logic [23:0] cnt_q, cnt_d;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  // Saturating +1/-1 on the granted nibble; add and sub together cancel.
  function automatic logic [15:0] score_update(input logic [15:0] s,
                                               input logic [3:0]  g,
                                               input logic        a,
                                               input logic        b);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (g[i] && a && !b) begin
        if (s[i*4 +: 4] < SCORE_MAX) r[i*4 +: 4] = s[i*4 +: 4] + 4'd1;
        else                         r[i*4 +: 4] = SCORE_MAX;
      end else if (g[i] && b && !a) begin
        if (s[i*4 +: 4] != 4'd0) r[i*4 +: 4] = s[i*4 +: 4] - 4'd1;
        else                     r[i*4 +: 4] = 4'd0;
      end else begin
        r[i*4 +: 4] = s[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Key synchronizer and edge register; flops clear on reset so a key held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      prev_q  <= 4'd0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_s     = sync2_q & ~prev_q;
  assign eligible_s = rise_s & ~foul_q;

  // Round sequencing, arbitration, countdown and scoring.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    foul_d   = foul_q;
    remain_d = remain_q;
    buzz_d   = buzz_q;
    scores_d = scores_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      scores_d = SCORES_INIT;
      state_d  = ST_IDLE;
      grant_d  = 4'd0;
      foul_d   = 4'd0;
      buzz_d   = 1'b0;
      remain_d = REMAIN_INIT;
      cnt_d    = 24'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Any press before the round is armed is a false start.
          foul_d = foul_q | rise_s;
          if (arm_i) state_d = ST_ARMED;
          else       state_d = ST_IDLE;
        end
        ST_ARMED: begin
          if (|eligible_s) begin
            grant_d  = lowest_one(eligible_s);
            remain_d = REMAIN_INIT;
            cnt_d    = 24'd0;
            state_d  = ST_ANSWER;
          end else if (arm_i) begin
            foul_d = 4'd0;
          end else begin
            foul_d = foul_q;
          end
        end
        ST_ANSWER: begin
          if (add_i || sub_i) begin
            scores_d = score_update(scores_q, grant_q, add_i, sub_i);
            grant_d  = 4'd0;
            foul_d   = 4'd0;
            buzz_d   = 1'b0;
            remain_d = REMAIN_INIT;
            state_d  = ST_IDLE;
          end else if (cnt_q == TICK_LAST) begin
            cnt_d = 24'd0;
            if (remain_q <= 5'd1) begin
              remain_d = 5'd0;
              buzz_d   = 1'b1;
              state_d  = ST_TIMEOUT;
            end else begin
              remain_d = remain_q - 5'd1;
            end
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
        ST_TIMEOUT: begin
          if (add_i || sub_i) begin
            scores_d = score_update(scores_q, grant_q, add_i, sub_i);
            grant_d  = 4'd0;
            foul_d   = 4'd0;
            buzz_d   = 1'b0;
            remain_d = REMAIN_INIT;
            state_d  = ST_IDLE;
          end else if (arm_i) begin
            grant_d  = 4'd0;
            buzz_d   = 1'b0;
            remain_d = REMAIN_INIT;
            state_d  = ST_ARMED;
          end else begin
            remain_d = 5'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Round state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      grant_q  <= 4'd0;
      foul_q   <= 4'd0;
      remain_q <= REMAIN_INIT;
      buzz_q   <= 1'b0;
      scores_q <= SCORES_INIT;
      cnt_q    <= 24'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      foul_q   <= foul_d;
      remain_q <= remain_d;
      buzz_q   <= buzz_d;
      scores_q <= scores_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant_o  = grant_q;
  assign foul_o   = foul_q;
  assign state_o  = state_q;
  assign remain_o = remain_q;
  assign buzz_o   = buzz_q;
  assign scores_o = scores_q;

endmodule

// File: tb/tb_quiz_arbiter.sv
module tb_quiz_arbiter;

  localparam int TD   = 4;
  localparam int AS   = 3;
  localparam int INIT = 5;
  localparam int MAXS = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, clr, add, sub;
  logic [3:0]  req;
  logic [3:0]  grant, foul;
  logic [1:0]  state;
  logic [4:0]  remain;
  logic        buzz;
  logic [15:0] scores;

  int n_checks = 0;
  int n_fail   = 0;

  quiz_arbiter #(.TICK_DIV(TD), .ANSWER_SEC(AS), .INIT_SCORE(INIT), .MAX_SCORE(MAXS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .arm_i(arm), .clr_i(clr), .add_i(add), .sub_i(sub),
    .req_i(req), .grant_o(grant), .foul_o(foul), .state_o(state), .remain_o(remain),
    .buzz_o(buzz), .scores_o(scores)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0..3, winner index (-1 none), integer scores,
  // cycles elapsed since the grant, and the last three sampled key words.
  int         m_phase;
  int         m_grant;
  logic [3:0] m_foul;
  int         m_score [4];
  int         m_elapsed;
  logic [3:0] m_hist [3];

  task automatic model_reset();
    m_phase = 0; m_grant = -1; m_foul = 4'd0; m_elapsed = 0;
    for (int i = 0; i < 4; i++) m_score[i] = INIT;
    for (int i = 0; i < 3; i++) m_hist[i] = 4'd0;
  endtask

  task automatic model_settle(input logic a, input logic s);
    if (a && !s) m_score[m_grant] = (m_score[m_grant] + 1 > MAXS) ? MAXS : m_score[m_grant] + 1;
    if (s && !a) m_score[m_grant] = (m_score[m_grant] - 1 < 0) ? 0 : m_score[m_grant] - 1;
    m_phase = 0; m_grant = -1; m_foul = 4'd0;
  endtask

  task automatic model_step();
    logic [3:0] rise, elig;
    rise = m_hist[1] & ~m_hist[2];
    if (clr) begin
      for (int i = 0; i < 4; i++) m_score[i] = INIT;
      m_phase = 0; m_grant = -1; m_foul = 4'd0;
    end else if (m_phase == 0) begin
      m_foul = m_foul | rise;
      if (arm) m_phase = 1;
    end else if (m_phase == 1) begin
      elig = rise & ~m_foul;
      if (elig != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (elig[i]) m_grant = i;
        m_phase = 2; m_elapsed = 0;
      end else if (arm) begin
        m_foul = 4'd0;
      end
    end else if (m_phase == 2) begin
      if (add || sub) model_settle(add, sub);
      else begin
        m_elapsed++;
        if (m_elapsed == AS * TD) m_phase = 3;
      end
    end else begin
      if (add || sub) model_settle(add, sub);
      else if (arm) begin m_grant = -1; m_phase = 1; end
    end
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = req;
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [15:0] es;
    int          er;
    for (int i = 0; i < 4; i++) es[i*4 +: 4] = 4'(m_score[i]);
    if (m_phase == 2)      er = AS - m_elapsed / TD;
    else if (m_phase == 3) er = 0;
    else                   er = AS;
    check("model_state",  32'(state),  32'(m_phase));
    check("model_grant",  32'(grant),  (m_grant < 0) ? 32'd0 : (32'd1 << m_grant));
    check("model_foul",   32'(foul),   32'(m_foul));
    check("model_buzz",   32'(buzz),   (m_phase == 3) ? 32'd1 : 32'd0);
    check("model_remain", 32'(remain), 32'(er));
    check("model_scores", 32'(scores), 32'(es));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_n) compare_model();
    end
  endtask

  task automatic pulse(input logic a, input logic c, input logic ad, input logic s);
    arm = a; clr = c; add = ad; sub = s;
    cyc(1);
    arm = 1'b0; clr = 1'b0; add = 1'b0; sub = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; clr = 1'b0; add = 1'b0; sub = 1'b0; req = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_state",  32'(state),  32'd0);
    check("reset_grant",  32'(grant),  32'd0);
    check("reset_remain", 32'(remain), 32'd3);
    check("reset_scores", 32'(scores), 32'h5555);
    rst_n = 1'b1;

    // Basic grant and award
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("arm_state", 32'(state), 32'd1);
    req = 4'b0100;
    cyc(2);
    check("grant_not_yet", 32'(grant), 32'd0);
    cyc(1);
    check("grant_e2", 32'(grant), 32'b0100);
    check("grant_state", 32'(state), 32'd2);
    check("grant_remain", 32'(remain), 32'd3);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("add_scores", 32'(scores), 32'h5655);
    check("add_state", 32'(state), 32'd0);
    check("add_grant", 32'(grant), 32'd0);
    req = 4'd0; cyc(3);

    // Simultaneous presses, later press ignored
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0011; cyc(3);
    check("simul_grant", 32'(grant), 32'b0001);
    req = 4'b0001; cyc(3);
    req = 4'b0011; cyc(3);
    check("late_press_grant", 32'(grant), 32'b0001);
    check("late_press_state", 32'(state), 32'd2);
    req = 4'd0;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("clr1_scores", 32'(scores), 32'h5555);
    cyc(3);

    // False start lockout
    req = 4'b1000; cyc(3);
    check("foul_idle", 32'(foul), 32'b1000);
    req = 4'd0; cyc(3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b1000; cyc(4);
    check("fouled_no_grant", 32'(grant), 32'd0);
    check("fouled_state", 32'(state), 32'd1);
    req = 4'b1010; cyc(3);
    check("after_foul_grant", 32'(grant), 32'b0010);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("sub_scores", 32'(scores), 32'h5545);
    check("sub_foul", 32'(foul), 32'd0);
    req = 4'd0; cyc(3);

    // Raise contestant 1 to the ceiling
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      req = 4'b0001; cyc(3);
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      req = 4'd0; cyc(3);
    end
    check("ceiling_scores", 32'(scores), 32'h5549);

    // Countdown and timeout, then saturated add
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0001; cyc(3);
    check("cd_grant", 32'(grant), 32'b0001);
    check("cd_remain0", 32'(remain), 32'd3);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      check("cd_remain", 32'(remain), (k < 12) ? 32'(3 - k / 4) : 32'd0);
    end
    check("timeout_state", 32'(state), 32'd3);
    check("timeout_buzz", 32'(buzz), 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_scores", 32'(scores), 32'h5549);
    check("sat_buzz", 32'(buzz), 32'd0);
    check("sat_state", 32'(state), 32'd0);
    req = 4'd0; cyc(3);

    // add+sub in TIMEOUT, then clr mid-answer
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0100; cyc(15);
    check("to2_state", 32'(state), 32'd3);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    check("addsub_scores", 32'(scores), 32'h5549);
    check("addsub_state", 32'(state), 32'd0);
    req = 4'd0; cyc(3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b1000; cyc(5);
    check("pre_clr_state", 32'(state), 32'd2);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_scores", 32'(scores), 32'h5555);
    check("clr_state", 32'(state), 32'd0);
    check("clr_grant", 32'(grant), 32'd0);
    req = 4'd0; cyc(3);

    // Asynchronous reset mid-answer
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    req = 4'b0010; cyc(4);
    check("pre_rst_state", 32'(state), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_buzz", 32'(buzz), 32'd0);
    check("async_remain", 32'(remain), 32'd3);
    req = 4'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      arm = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 80) == 0);
      add = ($urandom_range(0, 12) == 0);
      sub = ($urandom_range(0, 12) == 0);
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
      cyc(1);
    end
    arm = 1'b0; clr = 1'b0; add = 1'b0; sub = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
